// File: rtl/core_irq_pwr_ctrl.sv
// -----------------------------------------------------------------------------
// core_irq_pwr_ctrl
//
// Platform-side companion to core_top. Collects NUM_SRC level interrupt
// sources into pending / in-service state and serves them through a
// claim/complete handshake. Gates the core clock while the core sits in WFI
// with nothing pending, and issues a timed core reset request after an
// unexpected-error indication. Runs on the always-on clock.
//
// Ports:
//   clk               always-on clock
//   rst_n             asynchronous active-low reset
//   irq_src           level interrupt sources (synchronous to clk)
//   irq_en            per-source enable (gates new pends only)
//   extenal_interrupt to the core; high while any source is pending
//   claim_req         one-cycle claim strobe
//   claim_vld         one-cycle pulse qualifying claim_id
//   claim_id          claimed ID (source i -> i+1), 0 when nothing pending
//   complete_req      one-cycle complete strobe
//   complete_id       ID being completed
//   core_wfi          core waiting for interrupt
//   core_unexcp_err   core unexpected-error indication (edge-detected)
//   err_clr           clears err_sticky
//   core_clk_en       enable for the core clock gate
//   core_rst_req      active-high core reset request
//   err_sticky        latched error flag
// -----------------------------------------------------------------------------
module core_irq_pwr_ctrl #(
   parameter  int NUM_SRC        = 8,
   parameter  int ERR_RST_CYCLES = 16,
   localparam int IDW            = $clog2(NUM_SRC + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic [NUM_SRC-1:0] irq_en,
   output logic               extenal_interrupt,
   input  logic               claim_req,
   output logic               claim_vld,
   output logic [IDW-1:0]     claim_id,
   input  logic               complete_req,
   input  logic [IDW-1:0]     complete_id,
   input  logic               core_wfi,
   input  logic               core_unexcp_err,
   input  logic               err_clr,
   output logic               core_clk_en,
   output logic               core_rst_req,
   output logic               err_sticky
);

   typedef enum logic [1:0] {ST_RUN, ST_SLEEP, ST_WAKE, ST_ERR} state_t;

   localparam int            CW        = $clog2(ERR_RST_CYCLES);
   localparam logic [CW-1:0] ERR_LOAD  = CW'(ERR_RST_CYCLES - 1);
   localparam logic [CW-1:0] WAKE_LOAD = CW'(1);

   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] in_service;
   logic               err_q;
   state_t             state;
   logic [CW-1:0]      cnt;

   logic [NUM_SRC-1:0] set_vec;
   logic [NUM_SRC-1:0] lo_oh;
   logic [IDW-1:0]     lo_id;
   logic [NUM_SRC-1:0] claim_mask;
   logic [NUM_SRC-1:0] cmp_mask;
   logic [NUM_SRC-1:0] pend_nxt;
   logic [NUM_SRC-1:0] insvc_nxt;
   logic               err_edge;

   // Gateway, priority select, claim/complete masks and next-state vectors.
   always_comb begin
      // NOTE: every signal gets a default before any conditional assignment so
      // no path leaves a value unassigned and no latch is inferred.
      set_vec  = irq_src & irq_en & ~pending & ~in_service;
      lo_oh    = '0;
      lo_id    = '0;
      cmp_mask = '0;
      // Scan from the top down so the last hit, the lowest index, wins.
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pending[i]) begin
            lo_oh    = '0;
            lo_oh[i] = 1'b1;
            lo_id    = IDW'(i + 1);
         end
      end
      // Only an exact match on an in-service source completes; ID 0 and
      // out-of-range IDs never match any bit.
      for (int i = 0; i < NUM_SRC; i++) begin
         cmp_mask[i] = complete_req && (complete_id == IDW'(i + 1)) && in_service[i];
      end
      claim_mask = claim_req ? lo_oh : '0;
      err_edge   = core_unexcp_err & ~err_q;
      pend_nxt   = (pending & ~claim_mask) | set_vec;
      // An error abandons every handler in flight, including one claimed now.
      insvc_nxt  = err_edge ? '0 : ((in_service & ~cmp_mask) | claim_mask);
   end

   // Interrupt state, claim response and error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending           <= '0;
         in_service        <= '0;
         extenal_interrupt <= 1'b0;
         claim_vld         <= 1'b0;
         claim_id          <= '0;
         err_q             <= 1'b0;
         err_sticky        <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         pending           <= pend_nxt;
         in_service        <= insvc_nxt;
         extenal_interrupt <= |pend_nxt;
         claim_vld         <= claim_req;
         claim_id          <= claim_req ? lo_id : '0;
         err_q             <= core_unexcp_err;
         if (err_edge) begin
            err_sticky <= 1'b1;
         end else if (err_clr) begin
            err_sticky <= 1'b0;
         end
      end
   end

   // Power / error FSM with registered clock-enable and reset-request outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_RUN;
         cnt          <= '0;
         core_clk_en  <= 1'b1;
         core_rst_req <= 1'b0;
      end else if (err_edge) begin
         // Error edge overrides every other transition and restarts the timer.
         state        <= ST_ERR;
         cnt          <= ERR_LOAD;
         core_clk_en  <= 1'b1;
         core_rst_req <= 1'b1;
      end else begin
         unique case (state)
            ST_RUN: begin
               if (core_wfi && ~|pending) begin
                  state       <= ST_SLEEP;
                  core_clk_en <= 1'b0;
               end
            end
            ST_SLEEP: begin
               // Look at the next pending vector so the clock returns on the
               // same edge that latches the interrupt.
               if (|pend_nxt) begin
                  state       <= ST_WAKE;
                  cnt         <= WAKE_LOAD;
                  core_clk_en <= 1'b1;
               end
            end
            ST_WAKE: begin
               if (cnt == '0) begin
                  state <= ST_RUN;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_ERR: begin
               if (cnt == '0) begin
                  state        <= ST_RUN;
                  core_rst_req <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state        <= ST_RUN;
               core_clk_en  <= 1'b1;
               core_rst_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_irq_pwr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_irq_pwr_ctrl
//
// Self-checking bench for core_irq_pwr_ctrl. A behavioural model tracks the
// pending/in-service sets and the power behaviour as remaining-cycle counts;
// a compare process checks the DUT against it on every falling edge. Directed
// scenarios add literal expectations, then randomized traffic runs.
// -----------------------------------------------------------------------------
module tb_core_irq_pwr_ctrl;

   localparam int NUM_SRC        = 8;
   localparam int ERR_RST_CYCLES = 16;
   localparam int IDW            = $clog2(NUM_SRC + 1);

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NUM_SRC-1:0] irq_src = '0;
   logic [NUM_SRC-1:0] irq_en = '1;
   logic               extenal_interrupt;
   logic               claim_req = 1'b0;
   logic               claim_vld;
   logic [IDW-1:0]     claim_id;
   logic               complete_req = 1'b0;
   logic [IDW-1:0]     complete_id = '0;
   logic               core_wfi = 1'b0;
   logic               core_unexcp_err = 1'b0;
   logic               err_clr = 1'b0;
   logic               core_clk_en;
   logic               core_rst_req;
   logic               err_sticky;

   int n_checks = 0;
   int n_pass   = 0;

   core_irq_pwr_ctrl #(
      .NUM_SRC        (NUM_SRC),
      .ERR_RST_CYCLES (ERR_RST_CYCLES)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .irq_src           (irq_src),
      .irq_en            (irq_en),
      .extenal_interrupt (extenal_interrupt),
      .claim_req         (claim_req),
      .claim_vld         (claim_vld),
      .claim_id          (claim_id),
      .complete_req      (complete_req),
      .complete_id       (complete_id),
      .core_wfi          (core_wfi),
      .core_unexcp_err   (core_unexcp_err),
      .err_clr           (err_clr),
      .core_clk_en       (core_clk_en),
      .core_rst_req      (core_rst_req),
      .err_sticky        (err_sticky)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [NUM_SRC-1:0] pend;
      logic [NUM_SRC-1:0] insvc;
      logic               ext;
      logic               cvld;
      logic [IDW-1:0]     cid;
      logic               err_prev;
      logic               sticky;
      logic               asleep;
      int                 rst_left;   // reset-request cycles still to go
      int                 wake_left;  // forced-awake cycles still to go
   } model_t;

   localparam model_t M_RESET = '{default: '0};
   model_t m = M_RESET;

   function automatic model_t model_step(model_t s);
      model_t             n = s;
      logic               err_rise = core_unexcp_err && !s.err_prev;
      logic [NUM_SRC-1:0] newly = irq_src & irq_en & ~s.pend & ~s.insvc;
      int                 pick = -1;
      if (claim_req) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (s.pend[i] && pick < 0) pick = i;
         end
      end
      n.pend = s.pend | newly;
      if (pick >= 0) n.pend[pick] = 1'b0;
      if (complete_req && complete_id >= 1 && int'(complete_id) <= NUM_SRC
          && s.insvc[complete_id - 1]) begin
         n.insvc[complete_id - 1] = 1'b0;
      end
      if (pick >= 0) n.insvc[pick] = 1'b1;
      if (err_rise) n.insvc = '0;
      n.ext      = |n.pend;
      n.cvld     = claim_req;
      n.cid      = (pick >= 0) ? IDW'(pick + 1) : '0;
      n.err_prev = core_unexcp_err;
      if (err_rise)     n.sticky = 1'b1;
      else if (err_clr) n.sticky = 1'b0;
      if (err_rise) begin
         n.rst_left = ERR_RST_CYCLES; n.wake_left = 0; n.asleep = 1'b0;
      end else if (s.rst_left > 0) begin
         n.rst_left = s.rst_left - 1;
      end else if (s.wake_left > 0) begin
         n.wake_left = s.wake_left - 1;
      end else if (s.asleep) begin
         if (n.pend != '0) begin
            n.asleep = 1'b0; n.wake_left = 2;
         end
      end else if (core_wfi && s.pend == '0) begin
         n.asleep = 1'b1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= M_RESET;
      else        m <= model_step(m);
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("ext_int",    32'(extenal_interrupt), 32'(m.ext));
      check("claim_vld",  32'(claim_vld),         32'(m.cvld));
      check("claim_id",   32'(claim_id),          32'(m.cid));
      check("clk_en",     32'(core_clk_en),       32'(!m.asleep));
      check("rst_req",    32'(core_rst_req),      32'(m.rst_left > 0));
      check("err_sticky", 32'(err_sticky),        32'(m.sticky));
      check("pending",    32'(dut.pending),       32'(m.pend));
      check("in_service", 32'(dut.in_service),    32'(m.insvc));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      irq_src = '0; irq_en = '1; claim_req = 1'b0; complete_req = 1'b0;
      complete_id = '0; core_wfi = 1'b0; err_clr = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ext"},     32'(extenal_interrupt), 32'd0);
      check({tag, "_cvld"},    32'(claim_vld),         32'd0);
      check({tag, "_cid"},     32'(claim_id),          32'd0);
      check({tag, "_clk_en"},  32'(core_clk_en),       32'd1);
      check({tag, "_rst_req"}, 32'(core_rst_req),      32'd0);
      check({tag, "_sticky"},  32'(err_sticky),        32'd0);
   endtask

   initial begin
      int rst_cnt;
      rst_n = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Single source: pend, claim, complete.
      irq_src = 8'b0000_0100; tick(); irq_src = '0;
      check("t1_ext_set", 32'(extenal_interrupt), 32'd1);
      claim_req = 1'b1; tick(); claim_req = 1'b0;
      check("t1_cvld", 32'(claim_vld), 32'd1);
      check("t1_cid",  32'(claim_id),  32'd3);
      check("t1_ext_drop", 32'(extenal_interrupt), 32'd0);
      complete_req = 1'b1; complete_id = 4'd3; tick(); complete_req = 1'b0;
      check("t1_insvc_clr", 32'(dut.in_service), 32'd0);

      // Priority: sources 5 and 1, three claims.
      irq_src = 8'b0010_0010; tick(); irq_src = '0;
      claim_req = 1'b1;
      tick(); check("t2_cid_a", 32'(claim_id), 32'd2);
      tick(); check("t2_cid_b", 32'(claim_id), 32'd6);
      tick(); check("t2_cid_none", 32'(claim_id), 32'd0);
      check("t2_cvld_none", 32'(claim_vld), 32'd1);
      check("t2_insvc_kept", 32'(dut.in_service), 32'h22);
      claim_req = 1'b0;
      complete_req = 1'b1; complete_id = 4'd2; tick();
      complete_id = 4'd6; tick(); complete_req = 1'b0;

      // Held source: no re-pend while in service, re-pends after complete.
      irq_src = 8'b0000_0001; tick();
      check("t3_ext", 32'(extenal_interrupt), 32'd1);
      claim_req = 1'b1; tick(); claim_req = 1'b0;
      check("t3_cid", 32'(claim_id), 32'd1);
      tick(); check("t3_no_repend", 32'(extenal_interrupt), 32'd0);
      complete_req = 1'b1; complete_id = 4'd1; tick(); complete_req = 1'b0;
      check("t3_blocked", 32'(extenal_interrupt), 32'd0);
      tick(); check("t3_repend", 32'(extenal_interrupt), 32'd1);
      irq_src = '0;
      claim_req = 1'b1; tick(); claim_req = 1'b0;
      complete_req = 1'b1; complete_id = 4'd1; tick(); complete_req = 1'b0;

      // Sleep and wake.
      core_wfi = 1'b1; tick();
      check("t4_sleep", 32'(core_clk_en), 32'd0);
      irq_src = 8'b1000_0000; tick(); irq_src = '0;
      check("t4_wake_edge", 32'(core_clk_en), 32'd1);
      repeat (3) begin
         tick(); check("t4_awake", 32'(core_clk_en), 32'd1);
      end
      core_wfi = 1'b0;
      claim_req = 1'b1; tick(); claim_req = 1'b0;
      check("t4_cid", 32'(claim_id), 32'd8);
      complete_req = 1'b1; complete_id = 4'd8; tick(); complete_req = 1'b0;

      // Error from SLEEP with one handler in service and a new pend.
      irq_src = 8'b0000_1000; tick(); irq_src = '0;
      claim_req = 1'b1; tick(); claim_req = 1'b0;
      core_wfi = 1'b1; tick();
      check("t5_sleep", 32'(core_clk_en), 32'd0);
      core_unexcp_err = 1'b1; irq_src = 8'b0100_0000; tick(); irq_src = '0;
      check("t5_rst_req", 32'(core_rst_req), 32'd1);
      check("t5_clk_en",  32'(core_clk_en),  32'd1);
      check("t5_sticky",  32'(err_sticky),   32'd1);
      check("t5_insvc",   32'(dut.in_service), 32'd0);
      rst_cnt = 1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (core_rst_req) rst_cnt++;
         else break;
      end
      check("t5_rst_len", 32'(rst_cnt), 32'd16);
      check("t5_run", 32'(core_clk_en), 32'd1);
      check("t5_pend_kept", 32'(dut.pending), 32'h40);
      tick(); check("t5_sticky_hold", 32'(err_sticky), 32'd1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("t5_sticky_clr", 32'(err_sticky), 32'd0);
      core_unexcp_err = 1'b0; core_wfi = 1'b0;
      claim_req = 1'b1; tick(); claim_req = 1'b0;
      complete_req = 1'b1; complete_id = 4'd7; tick(); complete_req = 1'b0;

      // Reset mid-ERR.
      core_unexcp_err = 1'b1; tick();
      tick(); tick();
      check("t6_in_err", 32'(core_rst_req), 32'd1);
      rst_n = 1'b0; #1;
      check_reset_outputs("t6_async");
      core_unexcp_err = 1'b0;
      tick(); tick();
      rst_n = 1'b1; tick();
      check("t6_rst_req", 32'(core_rst_req), 32'd0);
      check("t6_clk_en",  32'(core_clk_en),  32'd1);
      core_wfi = 1'b1; tick(); core_wfi = 1'b0;
      check("t6_run_sleeps", 32'(core_clk_en), 32'd0);
      tick();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         irq_src   = NUM_SRC'($urandom & $urandom & $urandom);
         irq_en    = ($urandom_range(0, 7) == 0) ? NUM_SRC'($urandom) : '1;
         claim_req = ($urandom_range(0, 3) == 0);
         complete_req = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) == 0 || m.insvc == '0) begin
            complete_id = IDW'($urandom_range(0, NUM_SRC + 2));
         end else begin
            int k;
            k = $urandom_range(0, NUM_SRC - 1);
            while (!m.insvc[k]) k = (k + 1) % NUM_SRC;
            complete_id = IDW'(k + 1);
         end
         core_wfi = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 59) == 0) core_unexcp_err = ~core_unexcp_err;
         err_clr = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 799) == 0) begin
            #2 rst_n = 1'b0;
            tick(); tick();
            rst_n = 1'b1;
         end
         tick();
      end
      idle_inputs();
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/core_irq_pwr_ctrl.md
# core_irq_pwr_ctrl

Platform-side companion to `core_top` that drives its `extenal_interrupt` input and consumes its `core_wfi` and `core_unexcp_err` outputs. It gathers `NUM_SRC` level interrupt sources into pending/in-service state and serves them through a claim/complete handshake. It gates the core clock while the core sleeps in WFI with nothing pending, and issues a timed core reset request after an unexpected-error indication. It runs on the always-on clock beside the core.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources (1..31).
- `ERR_RST_CYCLES`, default 16: length of the core reset request in cycles (≥2).
- `IDW`: derived, `$clog2(NUM_SRC+1)`. Source i has ID i+1; ID 0 means "none".

Ports:
- `clk`  in  1: always-on clock; the only clock of the block.
- `rst_n`  in  1: asynchronous, active-low reset.
- `irq_src`  in  NUM_SRC: level interrupt sources, synchronous to `clk`.
- `irq_en`  in  NUM_SRC: per-source enable.
- `extenal_interrupt`  out  1: to the core; high while any pending bit is set.
- `claim_req`  in  1: one-cycle claim strobe from the core.
- `claim_vld`  out  1: one-cycle pulse; `claim_id` is valid.
- `claim_id`  out  IDW: claimed ID, or 0 if nothing was pending.
- `complete_req`  in  1: one-cycle complete strobe.
- `complete_id`  in  IDW: ID being completed.
- `core_wfi`  in  1: core is waiting for interrupt.
- `core_unexcp_err`  in  1: core unexpected-error indication.
- `err_clr`  in  1: clears `err_sticky`.
- `core_clk_en`  out  1: enable for the core clock gate.
- `core_rst_req`  out  1: active-high core reset request.
- `err_sticky`  out  1: latched error flag.

## Operation
- Gateway: `pending[i]` sets when `irq_src[i] & irq_en[i] & ~pending[i] & ~in_service[i]`. Deasserting `irq_en` blocks new sets only; an existing pending bit stays set.
- `extenal_interrupt` is a register equal to the OR of the next-state pending vector.
- Claim: on `claim_req`, the lowest-index set bit of the current `pending` register is selected. The block clears that pending bit, sets its `in_service` bit, and returns its ID. If no bit is pending, it returns ID 0 and changes no state.
- Complete: `complete_req` with a valid in-service ID clears that `in_service` bit. ID 0, an out-of-range ID, or an ID that is not in service is ignored.
- Claim and complete in the same cycle are both applied. A complete for source k and a new set of source k in the same cycle: the set is blocked that cycle and occurs the following cycle if the source is still high.
- Power/error FSM states are RUN, SLEEP, WAKE and ERR.
  - RUN: `core_clk_en`=1. Goes to SLEEP when `core_wfi` is high and `pending` is all zero.
  - SLEEP: `core_clk_en`=0. Goes to WAKE when any pending bit is set.
  - WAKE: `core_clk_en`=1 for exactly 2 cycles, then RUN. The block does not re-enter SLEEP until pending is all zero again.
  - ERR: entered from any state on a 0→1 edge of `core_unexcp_err`; this takes priority over all other transitions in that cycle. `core_rst_req`=1 and `core_clk_en`=1 for ERR_RST_CYCLES cycles, then RUN.
- Entering ERR sets `err_sticky` and clears all `in_service` bits; `pending` is retained. Another error edge while in ERR restarts the counter.
- `err_sticky` clears on `err_clr` unless an error edge arrives in the same cycle; set wins.

## Timing
- Reset values: `extenal_interrupt`=0, `claim_vld`=0, `claim_id`=0, `core_clk_en`=1, `core_rst_req`=0, `err_sticky`=0. `pending`=0, `in_service`=0, FSM=RUN, error edge detector=0.
- Assertion of `rst_n` mid-operation, including mid-ERR, returns every output to its reset value immediately.
- `irq_src` high at edge N: `pending` and `extenal_interrupt` are high after edge N.
- `claim_req` at edge N: `claim_vld` and `claim_id` appear after edge N for one cycle. The pending clear, and a drop of `extenal_interrupt` if that was the last pending bit, take effect at the same edge.
- SLEEP entry: `core_clk_en` falls one cycle after `core_wfi` is sampled high with nothing pending.
- Wake: the edge that sets pending also moves the FSM to WAKE, so `core_clk_en` rises at that same edge.
- ERR: `core_rst_req` rises one cycle after the error edge is sampled and stays high exactly ERR_RST_CYCLES cycles.

## Test plan
- Source 2 high (enabled) for 1 cycle → `extenal_interrupt`=1 next cycle. `claim_req` → `claim_vld`=1, `claim_id`=3, and `extenal_interrupt`=0 after the same edge. `complete_id`=3 → `in_service[2]` clears.
- Sources 5 and 1 pending; two claims → IDs 2 then 6. A third claim → ID 0 with no state change.
- Source 0 held high through claim and complete → no re-pend while in service. It re-pends one cycle after the complete; `extenal_interrupt` goes high again.
- `core_wfi`=1 with nothing pending → `core_clk_en`=0 next cycle. Raise source 7 → `core_clk_en`=1 at the pend edge, held ≥2 cycles, then state is RUN.
- `core_unexcp_err` 0→1 while in SLEEP → `core_rst_req` high exactly 16 cycles, `core_clk_en`=1, `err_sticky`=1 until `err_clr`, `in_service`=0, pending retained.
- `rst_n` low mid-ERR → all outputs at reset values at once. After release, `core_rst_req`=0 and the FSM is in RUN.
